// File: rtl/otter_cache_pkg.sv
// Shared widths, types and helpers for the direct-mapped write-back otter_cache.
package otter_cache_pkg;

    localparam int NUM_SETS   = 16;
    localparam int LINE_BITS  = 256;
    localparam int LINE_WORDS = 8;
    localparam int OFFSET_W   = 5;
    localparam int INDEX_W    = $clog2(NUM_SETS);
    localparam int TAG_W      = 32 - OFFSET_W - INDEX_W;

    typedef logic [TAG_W-1:0]              tag_t;
    typedef logic [INDEX_W-1:0]            index_t;
    typedef logic [$clog2(LINE_WORDS)-1:0] word_sel_t;
    typedef logic [LINE_BITS-1:0]          line_t;

    typedef enum logic [1:0] {CHECK, WRITEBACK, ALLOCATE} cache_state_t;

    // Expands 4 byte strobes into a 32-bit lane mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/otter_cache_if.sv
// CPU word port plus cacheline memory port of otter_cache, bundled as one interface.
interface otter_cache_if;

    logic [31:0]                           mem_address;
    logic                                  mem_read;
    logic                                  mem_write;
    logic [31:0]                           mem_wdata;
    logic [3:0]                            mem_byte_enable;
    logic [31:0]                           mem_rdata;
    logic                                  mem_resp;
    logic [31:0]                           pmem_address;
    logic                                  pmem_read;
    logic                                  pmem_write;
    logic [otter_cache_pkg::LINE_BITS-1:0] pmem_wdata;
    logic [otter_cache_pkg::LINE_BITS-1:0] pmem_rdata;
    logic                                  pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata
    );

endinterface

// File: rtl/otter_cache_array.sv
// Per-set valid/dirty/tag/data storage: combinational read, byte-merge write, line fill.
module otter_cache_array
    import otter_cache_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  index_t    idx,
    input  logic      word_we,
    input  word_sel_t word_sel,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    input  logic      fill,
    input  tag_t      fill_tag,
    input  line_t     fill_data,
    input  logic      clr_dirty,
    output logic      valid,
    output logic      dirty,
    output tag_t      tag,
    output line_t     line
);

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    tag_t                tag_q  [NUM_SETS];
    line_t               data_q [NUM_SETS];

    logic [7:0]  word_base;
    logic [31:0] merged;

    assign valid     = valid_q[idx];
    assign dirty     = dirty_q[idx];
    assign tag       = tag_q[idx];
    assign line      = data_q[idx];
    assign word_base = {word_sel, 5'b0};
    assign merged    = (line[word_base +: 32] & ~byte_mask(be)) | (wdata & byte_mask(be));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end else if (clr_dirty) begin
            dirty_q[idx] <= 1'b0;
        end
    end

    // NOTE: tag/data arrays are not reset; valid qualifies them, and a reset would rule out RAM mapping.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_data;
        end else if (word_we) begin
            data_q[idx][word_base +: 32] <= merged;
        end
    end

endmodule

// File: rtl/otter_cache.sv
// Direct-mapped write-back/write-allocate cache: hit logic and CHECK/WRITEBACK/ALLOCATE FSM.
module otter_cache
    import otter_cache_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    otter_cache_if.slave bus
);

    cache_state_t state, state_next;

    tag_t        addr_tag;
    index_t      idx;
    word_sel_t   word_sel;
    logic        req, hit;
    logic        valid, dirty;
    tag_t        tag;
    line_t       line;
    logic [31:0] cur_word;
    logic        word_we, fill, clr_dirty;

    assign addr_tag = bus.mem_address[31 -: TAG_W];
    assign idx      = bus.mem_address[OFFSET_W +: INDEX_W];
    assign word_sel = bus.mem_address[OFFSET_W-1 -: $bits(word_sel_t)];
    assign req      = bus.mem_read | bus.mem_write;
    assign hit      = valid && (tag == addr_tag);
    assign cur_word = line[{word_sel, 5'b0} +: 32];

    otter_cache_array u_array (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx),
        .word_we   (word_we),
        .word_sel  (word_sel),
        .wdata     (bus.mem_wdata),
        .be        (bus.mem_byte_enable),
        .fill      (fill),
        .fill_tag  (addr_tag),
        .fill_data (bus.pmem_rdata),
        .clr_dirty (clr_dirty),
        .valid     (valid),
        .dirty     (dirty),
        .tag       (tag),
        .line      (line)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= CHECK;
        else      state <= state_next;
    end

    // NOTE: every output gets a default first so no path through the case leaves a latch behind.
    always_comb begin
        state_next       = state;
        bus.mem_resp     = 1'b0;
        bus.mem_rdata    = '0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        word_we          = 1'b0;
        fill             = 1'b0;
        clr_dirty        = 1'b0;
        unique case (state)
            CHECK: begin
                if (req) begin
                    if (hit) begin
                        // Read+write together resolves as a write.
                        bus.mem_resp  = 1'b1;
                        bus.mem_rdata = cur_word;
                        word_we       = bus.mem_write;
                    end else if (valid && dirty) begin
                        state_next = WRITEBACK;
                    end else begin
                        state_next = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag, idx, OFFSET_W'(0)};
                bus.pmem_wdata   = line;
                if (bus.pmem_resp) begin
                    clr_dirty  = 1'b1;
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {addr_tag, idx, OFFSET_W'(0)};
                if (bus.pmem_resp) begin
                    fill       = 1'b1;
                    state_next = CHECK;
                end
            end
            default: state_next = CHECK;
        endcase
    end

endmodule

// File: tb/tb_otter_cache.sv
// Self-checking bench for otter_cache: directed scenarios plus random traffic against a memory-view model.
module tb_otter_cache;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    otter_cache_if ifc ();
    otter_cache dut (.clk(clk), .rst(rst), .bus(ifc));

    int compared = 0;
    int mismatched = 0;

    ev_t          ev_q[$];
    logic [31:0]  ref_mem [logic [31:0]];
    logic [255:0] bk      [logic [31:0]];
    logic [31:0]  res_line [16];
    bit           res_valid[16];
    bit           res_dirty[16];

    bit hold_resp = 1'b0;
    bit both_seen = 1'b0;
    bit stable_err = 1'b0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return 32'h1000_0000 + (((a >> 5) - 32'd8) << 8) + ((a >> 2) & 32'd7);
    endfunction

    function automatic logic [255:0] bk_line(input logic [31:0] la);
        logic [255:0] l;
        if (bk.exists(la)) return bk[la];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(la + 32'(i*4));
        return l;
    endfunction

    function automatic logic [31:0] bk_word(input logic [31:0] a);
        logic [255:0] l;
        l = bk_line(a & ~32'd31);
        return l[((a >> 2) & 32'd7)*32 +: 32];
    endfunction

    function automatic logic [31:0] ref_get(input logic [31:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = ref_get(la + 32'(i*4));
        return l;
    endfunction

    // CPU-visible memory plus which line each set holds and whether it was modified.
    task automatic model_update(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                                input logic [3:0] be);
        logic [31:0] la, w, v;
        int s;
        la = a & ~32'd31;
        w  = a & ~32'd3;
        s  = int'((a >> 5) & 32'd15);
        if (!(res_valid[s] && res_line[s] == la)) begin
            res_valid[s] = 1'b1;
            res_line[s]  = la;
            res_dirty[s] = 1'b0;
        end
        if (wr) begin
            v = ref_get(w);
            for (int b = 0; b < 4; b++) if (be[b]) v[b*8 +: 8] = wd[b*8 +: 8];
            ref_mem[w]   = v;
            res_dirty[s] = 1'b1;
        end
    endtask

    // Reset discards modified lines, so the CPU view falls back to backing memory.
    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            if (res_valid[s] && res_dirty[s])
                for (int i = 0; i < 8; i++) ref_mem[res_line[s] + 32'(i*4)] = bk_word(res_line[s] + 32'(i*4));
            res_valid[s] = 1'b0;
            res_dirty[s] = 1'b0;
        end
    endtask

    // Line memory responder with random latency; logs every completed transfer.
    initial begin : responder
        int wait_cnt;
        logic [31:0]  cap_addr;
        bit           cap_wr;
        logic [255:0] cap_data;
        ev_t e;
        wait_cnt = 0;
        ifc.pmem_resp  = 1'b0;
        ifc.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            ifc.pmem_resp = 1'b0;
            if (rst && (ifc.pmem_read || ifc.pmem_write)) begin
                if (ifc.pmem_read && ifc.pmem_write) both_seen = 1'b1;
                if (wait_cnt == 0) begin
                    wait_cnt = $urandom_range(1, 3);
                    cap_addr = ifc.pmem_address;
                    cap_wr   = ifc.pmem_write;
                    cap_data = ifc.pmem_wdata;
                end else if (cap_addr !== ifc.pmem_address || cap_wr !== ifc.pmem_write ||
                             (cap_wr && cap_data !== ifc.pmem_wdata)) begin
                    stable_err = 1'b1;
                end
                if (!hold_resp) begin
                    wait_cnt--;
                    if (wait_cnt == 0) begin
                        e.wr   = cap_wr;
                        e.addr = ifc.pmem_address;
                        if (cap_wr) begin
                            e.data = ifc.pmem_wdata;
                            bk[e.addr] = e.data;
                        end else begin
                            e.data = bk_line(e.addr);
                            ifc.pmem_rdata = e.data;
                        end
                        ev_q.push_back(e);
                        ifc.pmem_resp = 1'b1;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Starts and ends on a negedge; cycles counts negedges waited before mem_resp.
    task automatic access(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rdata, output int cycles);
        bit ok;
        ev_q.delete();
        ifc.mem_address     = a;
        ifc.mem_read        = rd;
        ifc.mem_write       = wr;
        ifc.mem_wdata       = wd;
        ifc.mem_byte_enable = be;
        cycles = 0;
        ok     = 1'b0;
        rdata  = 'x;
        while (cycles < 60) begin
            #1;
            if (ifc.mem_resp) begin
                ok    = 1'b1;
                rdata = ifc.mem_rdata;
                break;
            end
            @(negedge clk);
            cycles++;
        end
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL access_timeout: addr %h got no mem_resp within %0d cycles, required a response", a, cycles);
        end
        @(posedge clk);
        #1;
        ifc.mem_read  = 1'b0;
        ifc.mem_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        ifc.mem_address = 32'h104; ifc.mem_read = 1'b1; ifc.mem_write = 1'b0;
        ifc.mem_wdata = '0; ifc.mem_byte_enable = '0;
        #12;
        compared++; if (ifc.mem_resp !== 1'b0) begin mismatched++; $display("FAIL reset_mem_resp: got %b want 0", ifc.mem_resp); end
        compared++; if (ifc.pmem_read !== 1'b0) begin mismatched++; $display("FAIL reset_pmem_read: got %b want 0", ifc.pmem_read); end
        compared++; if (ifc.pmem_write !== 1'b0) begin mismatched++; $display("FAIL reset_pmem_write: got %b want 0", ifc.pmem_write); end
        compared++; if (ifc.mem_rdata !== 32'h0) begin mismatched++; $display("FAIL reset_mem_rdata: got %h want 0", ifc.mem_rdata); end
        compared++; if (ifc.pmem_address !== 32'h0) begin mismatched++; $display("FAIL reset_pmem_address: got %h want 0", ifc.pmem_address); end
        ifc.mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_cold_read();
        logic [31:0] rd; int cyc;
        access(32'h104, 1, 0, 0, 0, rd, cyc);
        compared++; if (ev_q.size() != 1) begin mismatched++; $display("FAIL cold_traffic: got %0d transfers want 1", ev_q.size()); end
        else begin
            compared++; if (ev_q[0].wr !== 1'b0 || ev_q[0].addr !== 32'h100) begin mismatched++; $display("FAIL cold_fill: got wr=%b addr=%h want read of 00000100", ev_q[0].wr, ev_q[0].addr); end
        end
        compared++; if (rd !== 32'h1000_0001) begin mismatched++; $display("FAIL cold_rdata: got %h want 10000001", rd); end
        model_update(32'h104, 0, 0, 0);
        access(32'h108, 1, 0, 0, 0, rd, cyc);
        compared++; if (cyc != 0 || ev_q.size() != 0) begin mismatched++; $display("FAIL reread_hit: got %0d cycles %0d transfers want 0/0", cyc, ev_q.size()); end
        compared++; if (rd !== 32'h1000_0002) begin mismatched++; $display("FAIL reread_rdata: got %h want 10000002", rd); end
        model_update(32'h108, 0, 0, 0);
    endtask

    task automatic test_write_hit();
        logic [31:0] rd; int cyc;
        access(32'h104, 0, 1, 32'hDEAD_BEEF, 4'b0011, rd, cyc);
        compared++; if (cyc != 0 || ev_q.size() != 0) begin mismatched++; $display("FAIL write_hit: got %0d cycles %0d transfers want 0/0", cyc, ev_q.size()); end
        model_update(32'h104, 1, 32'hDEAD_BEEF, 4'b0011);
        access(32'h104, 1, 0, 0, 0, rd, cyc);
        compared++; if (rd !== 32'h1000_BEEF || ev_q.size() != 0) begin mismatched++; $display("FAIL write_merge: got %h (%0d transfers) want 1000beef (0)", rd, ev_q.size()); end
    endtask

    task automatic test_dirty_evict();
        logic [31:0] rd; int cyc;
        access(32'h304, 1, 0, 0, 0, rd, cyc);
        compared++; if (ev_q.size() != 2) begin mismatched++; $display("FAIL dirty_traffic: got %0d transfers want 2", ev_q.size()); end
        else begin
            compared++; if (ev_q[0].wr !== 1'b1 || ev_q[0].addr !== 32'h100 || ev_q[0].data[63:32] !== 32'h1000_BEEF)
                begin mismatched++; $display("FAIL dirty_wb: got wr=%b addr=%h w1=%h want write 00000100 w1=1000beef", ev_q[0].wr, ev_q[0].addr, ev_q[0].data[63:32]); end
            compared++; if (ev_q[1].wr !== 1'b0 || ev_q[1].addr !== 32'h300) begin mismatched++; $display("FAIL dirty_fill: got wr=%b addr=%h want read 00000300", ev_q[1].wr, ev_q[1].addr); end
        end
        compared++; if (rd !== 32'h1000_1001) begin mismatched++; $display("FAIL dirty_rdata: got %h want 10001001", rd); end
        compared++; if (ifc.mem_resp !== 1'b0) begin mismatched++; $display("FAIL dirty_single_resp: got mem_resp=%b after access want 0", ifc.mem_resp); end
        model_update(32'h304, 0, 0, 0);
    endtask

    task automatic test_clean_evict();
        logic [31:0] rd; int cyc;
        access(32'h500, 1, 0, 0, 0, rd, cyc);
        compared++; if (ev_q.size() != 1) begin mismatched++; $display("FAIL clean_traffic: got %0d transfers want 1", ev_q.size()); end
        else begin
            compared++; if (ev_q[0].wr !== 1'b0 || ev_q[0].addr !== 32'h500) begin mismatched++; $display("FAIL clean_fill: got wr=%b addr=%h want read 00000500", ev_q[0].wr, ev_q[0].addr); end
        end
        compared++; if (rd !== 32'h1000_2000) begin mismatched++; $display("FAIL clean_rdata: got %h want 10002000", rd); end
        model_update(32'h500, 0, 0, 0);
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; int cyc;
        hold_resp = 1'b1;
        ifc.mem_address = 32'h704; ifc.mem_read = 1'b1; ifc.mem_write = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        compared++; if (ifc.pmem_read !== 1'b1 || ifc.pmem_address !== 32'h700) begin mismatched++; $display("FAIL abort_pending: got read=%b addr=%h want 1/00000700", ifc.pmem_read, ifc.pmem_address); end
        #1 rst = 1'b0;
        #1;
        compared++; if (ifc.pmem_read !== 1'b0 || ifc.pmem_write !== 1'b0 || ifc.mem_resp !== 1'b0)
            begin mismatched++; $display("FAIL abort_drop: got read=%b write=%b resp=%b want 0/0/0", ifc.pmem_read, ifc.pmem_write, ifc.mem_resp); end
        model_reset();
        ifc.mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        hold_resp = 1'b0;
        access(32'h704, 1, 0, 0, 0, rd, cyc);
        compared++; if (ev_q.size() != 1 || ev_q[0].addr !== 32'h700) begin mismatched++; $display("FAIL abort_remiss: got %0d transfers want one fill of 00000700", ev_q.size()); end
        compared++; if (rd !== 32'h1000_3001) begin mismatched++; $display("FAIL abort_rdata: got %h want 10003001", rd); end
        model_update(32'h704, 0, 0, 0);
    endtask

    task automatic test_hold_read();
        logic [31:0] d1, d2; logic r1, r2;
        ifc.mem_address = 32'h708; ifc.mem_read = 1'b1; ifc.mem_write = 1'b0;
        #1; r1 = ifc.mem_resp; d1 = ifc.mem_rdata;
        @(negedge clk);
        #1; r2 = ifc.mem_resp; d2 = ifc.mem_rdata;
        compared++; if (r1 !== 1'b1 || r2 !== 1'b1) begin mismatched++; $display("FAIL hold_resp: got %b,%b want 1,1", r1, r2); end
        compared++; if (d1 !== 32'h1000_3002 || d2 !== 32'h1000_3002) begin mismatched++; $display("FAIL hold_rdata: got %h,%h want 10003002 twice", d1, d2); end
        @(posedge clk); #1; ifc.mem_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic r1;
        ifc.mem_address = 32'h70C; ifc.mem_read = 1'b0; ifc.mem_write = 1'b1;
        ifc.mem_wdata = 32'hCAFE_F00D; ifc.mem_byte_enable = 4'b1100;
        #1; r1 = ifc.mem_resp;
        @(posedge clk); #1;
        ifc.mem_write = 1'b0; ifc.mem_read = 1'b1;
        @(negedge clk); #1;
        compared++; if (r1 !== 1'b1 || ifc.mem_resp !== 1'b1 || ifc.mem_rdata !== 32'hCAFE_3003)
            begin mismatched++; $display("FAIL b2b_write_read: got resp=%b,%b data=%h want 1,1 cafe3003", r1, ifc.mem_resp, ifc.mem_rdata); end
        @(posedge clk); #1; ifc.mem_read = 1'b0;
        @(negedge clk);
        model_update(32'h70C, 1, 32'hCAFE_F00D, 4'b1100);
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rd, la, victim;
        logic [255:0] exp_wb;
        logic [3:0] be;
        bit r, w, hit, wb;
        int s, cyc, kind, nexp;
        repeat (300) begin
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5) |
                (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            kind = $urandom_range(0, 9);
            r  = (kind < 5) || (kind == 9);
            w  = (kind >= 5);
            wd = $urandom;
            be = 4'($urandom_range(0, 15));
            la = a & ~32'd31;
            s  = int'((a >> 5) & 32'd15);
            hit    = res_valid[s] && res_line[s] == la;
            wb     = !hit && res_valid[s] && res_dirty[s];
            victim = res_line[s];
            exp_wb = ref_line(victim);
            nexp   = hit ? 0 : (wb ? 2 : 1);
            access(a, r, w, wd, be, rd, cyc);
            compared++; if (ev_q.size() != nexp) begin mismatched++; $display("FAIL rand_traffic: addr %h got %0d transfers want %0d", a, ev_q.size(), nexp); end
            else if (nexp > 0) begin
                if (wb) begin
                    compared++; if (ev_q[0].wr !== 1'b1 || ev_q[0].addr !== victim || ev_q[0].data !== exp_wb)
                        begin mismatched++; $display("FAIL rand_wb: got wr=%b addr=%h want write of %h with modified data", ev_q[0].wr, ev_q[0].addr, victim); end
                end
                compared++; if (ev_q[nexp-1].wr !== 1'b0 || ev_q[nexp-1].addr !== la)
                    begin mismatched++; $display("FAIL rand_fill: got wr=%b addr=%h want read %h", ev_q[nexp-1].wr, ev_q[nexp-1].addr, la); end
            end
            compared++; if (hit ? (cyc != 0) : (cyc < 2)) begin mismatched++; $display("FAIL rand_latency: addr %h hit=%b got %0d cycles", a, hit, cyc); end
            if (r && !w) begin
                compared++; if (rd !== ref_get(a & ~32'd3)) begin mismatched++; $display("FAIL rand_rdata: addr %h got %h want %h", a, rd, ref_get(a & ~32'd3)); end
            end
            model_update(a, w, wd, be);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_bus_rules();
        compared++; if (both_seen) begin mismatched++; $display("FAIL pmem_exclusive: got pmem_read and pmem_write together, want never"); end
        compared++; if (stable_err) begin mismatched++; $display("FAIL pmem_stable: got address/data change while request held, want stable"); end
    endtask

    initial begin
        for (int s = 0; s < 16; s++) begin res_valid[s] = 1'b0; res_dirty[s] = 1'b0; res_line[s] = '0; end
        test_reset();
        test_cold_read();
        test_write_hit();
        test_dirty_evict();
        test_clean_evict();
        test_reset_abort();
        test_hold_read();
        test_back_to_back();
        test_random();
        test_bus_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
